uart_msg_tx: RTL and testbench
==============================

# uart_msg_tx

Parametrised message transmitter: a writable byte buffer, sent as one block of back-to-back UART frames on request or on a periodic auto-repeat. It replaces the fixed four-character sender and its derived baud clock. Everything runs in one clock domain, with an internal baud clock-enable. It sits between control logic, which loads and triggers messages, and the FPGA serial pin.

## Interface
- CLK_HZ, 24000000: system clock frequency.
- BAUD, 115200: line rate. DIV = round(CLK_HZ/BAUD) must be at least 2.
- DEPTH, 16: buffer size in bytes, minimum 1. AW = max(1, clog2(DEPTH)).
- STOP_BITS, 1: number of stop bits, 1 or 2.
- PERIOD_CYC, 0: auto-repeat period in clock cycles. 0 disables auto-repeat.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW  buffer write address. Writes with wr_addr ≥ DEPTH are ignored.
- wr_data  in  8  buffer write data.
- msg_len  in  AW+1  number of bytes to send, sampled at block start.
- send  in  1  block request, level-sampled each cycle.
- busy  out  1  a block is in progress.
- done  out  1  one-cycle pulse at the end of a block.
- serial  out  1  UART TX line, idle high.
- byte_idx  out  AW  index of the byte currently being framed (debug).

## Operation
- Reset values: serial=1, busy=0, done=0, byte_idx=0, FSM=IDLE, repeat counter=0. Buffer contents are not reset.
- Block start: occurs on send=1 in IDLE, or on a repeat tick in IDLE.
  - Latch len = min(msg_len, DEPTH). Set byte index to 0.
  - If len=0: pulse done the next cycle and never assert busy.
- send or a repeat tick while busy=1 is ignored. It is not queued.
- FSM states: IDLE → LOAD → START → DATA → STOP → (LOAD | FIN) → IDLE.
  - LOAD: read buffer[idx] into the shift register. This takes zero line time; it is merged with the START entry cycle.
  - START: serial=0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each.
  - STOP: serial=1 for STOP_BITS×DIV cycles. Then idx+1 < len → LOAD with idx+1; otherwise → FIN.
  - FIN: done=1 and busy=0 in the same cycle, then IDLE.
- Bytes within a block are sent back-to-back, with no idle gap between a stop bit and the next start bit.
- The baud counter reloads at every frame start, so there is no phase drift carried across bytes.
- Writes are accepted at all times. A write takes effect for any byte not yet loaded. A byte already in the shift register is unaffected.
- Auto-repeat: a counter of width clog2(PERIOD_CYC) runs freely and produces a one-cycle tick when it wraps at PERIOD_CYC−1. A tick arriving during busy is dropped.

## Timing
- send high in cycle t (IDLE): busy=1 and serial=0 from cycle t+1.
- Frame length: F = (9+STOP_BITS)×DIV cycles.
- Block length: len×F cycles of busy. The done pulse is in the first cycle after the final stop bit.
- A new send accepted in the done cycle starts the next block at done+1, so the minimum inter-block gap is 1 cycle.
- byte_idx updates in the cycle the START bit of that byte begins.
- Reset mid-frame: serial=1 and busy=0 in the cycle after rst. No done pulse is issued.
- Simultaneous send and repeat tick in IDLE: a single block starts.

## Structure
- Shared package uart_pkg holds:
  - The state enum.
  - A constant function computing DIV from CLK_HZ/BAUD with rounding, plus an elaboration check that DIV ≥ 2 and STOP_BITS ∈ {1,2}.
- Sub-module uart_tx_frame: baud counter, 10/11-bit shifter, and load/ready handshake. It takes a one-cycle load strobe with a data byte and returns a one-cycle frame_done.
- The top level holds the buffer (inferred distributed RAM), block FSM, length/index counters and repeat timer.

## Test plan
All scenarios use CLK_HZ=1000000, BAUD=250000 (DIV=4), DEPTH=4, STOP_BITS=1.
- Buffer "ABCD" (0x41..0x44), msg_len=4, pulse send → 4 frames. First frame's line is 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles. busy is high for 160 cycles, then a single done pulse.
- msg_len=0, send → done pulses at t+1. busy stays 0 and serial stays 1.
- msg_len=7 → exactly 4 frames sent (clamped to DEPTH).
- send held high during a block → ignored. With send still high at done, the next block starts the following cycle with a gap of exactly 1 idle cycle.
- PERIOD_CYC=100, msg_len=2 → a block starts every 100 cycles. With PERIOD_CYC=50 and msg_len=2 (80 cycles busy), every other tick is dropped.
- rst asserted mid-DATA of byte 1 → serial=1 and busy=0 next cycle, no done. A following send restarts at byte 0. Repeat with STOP_BITS=2 to check a 44-cycle frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART message transmitter.
// Holds the state enum used by the block and frame FSMs, the baud divider
// calculation with rounding, and the parameter legality check.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_FIN
  } uart_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic bit uart_params_ok(input int unsigned div,
                                        input int unsigned stop_bits);
    return (div >= 2) && ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// Single UART frame serialiser: start bit, 8 data bits LSB first, 1 or 2 stop bits.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   load, data    one-cycle strobe with the byte to send; restarts the baud counter
//   serial        registered TX line, idle high
//   ready_c       frame engine can accept a load this cycle
//   frame_done_c  last cycle of the final stop bit
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DIV       = 4,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       serial,
  output logic       ready_c,
  output logic       frame_done_c
);

  localparam int unsigned CW = $clog2(DIV);

  uart_state_e   phase;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          baud_end_c;

  assign baud_end_c   = (baud_cnt == CW'(DIV - 1));
  assign frame_done_c = (phase == ST_STOP) && baud_end_c && (bit_cnt == 4'(STOP_BITS - 1));
  assign ready_c      = (phase == ST_IDLE) || frame_done_c;

  // Load wins over everything, so a back-to-back byte replaces the last stop cycle's exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= ST_IDLE;
      serial   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (load) begin
      phase    <= ST_START;
      serial   <= 1'b0;
      shreg    <= data;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (phase != ST_IDLE) begin
      baud_cnt <= baud_end_c ? '0 : baud_cnt + CW'(1);
      if (baud_end_c) begin
        case (phase)
          ST_START: begin
            phase  <= ST_DATA;
            serial <= shreg[0];
          end
          ST_DATA: begin
            if (bit_cnt == 4'd7) begin
              phase   <= ST_STOP;
              serial  <= 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              shreg   <= {1'b1, shreg[7:1]};
              serial  <= shreg[1];
            end
          end
          ST_STOP: begin
            if (bit_cnt == 4'(STOP_BITS - 1)) phase <= ST_IDLE;
            else                              bit_cnt <= bit_cnt + 4'd1;
          end
          default: phase <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_msg_tx.sv
// Message transmitter: writable byte buffer sent as a block of back-to-back
// UART frames on request or on a periodic auto-repeat tick.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   wr_en/addr/data     buffer write port, accepted at all times
//   msg_len             bytes to send, sampled at block start, clamped to DEPTH
//   send                block request, level-sampled while idle
//   busy, done          block in progress / one-cycle end-of-block pulse
//   serial              UART TX line
//   byte_idx            index of the byte currently framed
module uart_msg_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 24000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PERIOD_CYC = 0,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW:0]   msg_len,
  input  logic          send,
  output logic          busy,
  output logic          done,
  output logic          serial,
  output logic [AW-1:0] byte_idx
);

  localparam int unsigned DIV = uart_div(CLK_HZ, BAUD);
  localparam int unsigned RW  = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  if (!uart_params_ok(DIV, STOP_BITS)) begin : g_param_check
    $error("uart_msg_tx: clocks per bit must be >= 2 and STOP_BITS must be 1 or 2");
  end

  uart_state_e st;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] blk_len;
  logic [AW:0] len_c, nxt_c;
  logic [AW-1:0] rd_addr_c;
  logic        tick_c, start_c, more_c, load_c, ready_c, frame_done_c;

  // Buffer: no reset, asynchronous read.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) mem[wr_addr] <= wr_data;
  end

  // Free-running repeat timer; tick on the wrap cycle.
  if (PERIOD_CYC > 0) begin : g_rep
    logic [RW-1:0] rep_cnt;
    always_ff @(posedge clk) begin
      if (rst)                                  rep_cnt <= '0;
      else if (rep_cnt == RW'(PERIOD_CYC - 1))  rep_cnt <= '0;
      else                                      rep_cnt <= rep_cnt + RW'(1);
    end
    assign tick_c = (rep_cnt == RW'(PERIOD_CYC - 1));
  end else begin : g_no_rep
    assign tick_c = 1'b0;
  end

  assign len_c     = (32'(msg_len) > DEPTH) ? (AW+1)'(DEPTH) : msg_len;
  assign nxt_c     = (AW+1)'(byte_idx) + (AW+1)'(1);
  assign more_c    = (nxt_c < blk_len);
  // The done cycle (FIN) also accepts a request, giving a one-cycle minimum gap.
  assign start_c   = ((st == ST_IDLE) || (st == ST_FIN)) && (send || tick_c);
  assign rd_addr_c = (st == ST_LOAD) ? nxt_c[AW-1:0] : '0;
  // Buffer read is merged into the start-bit entry, so loading costs no line time.
  assign load_c    = ready_c && ((start_c && (len_c != '0)) ||
                                 ((st == ST_LOAD) && frame_done_c && more_c));

  uart_tx_frame #(
    .DIV       (DIV),
    .STOP_BITS (STOP_BITS)
  ) u_frame (
    .clk          (clk),
    .rst          (rst),
    .load         (load_c),
    .data         (mem[rd_addr_c]),
    .serial       (serial),
    .ready_c      (ready_c),
    .frame_done_c (frame_done_c)
  );

  // Block FSM; ST_LOAD spans the whole block, each frame end triggers the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_idx <= '0;
      blk_len  <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        ST_IDLE, ST_FIN: begin
          busy <= 1'b0;
          st   <= ST_IDLE;
          if (start_c) begin
            blk_len  <= len_c;
            byte_idx <= '0;
            if (len_c == '0) begin
              st   <= ST_FIN;
              done <= 1'b1;
            end else begin
              st   <= ST_LOAD;
              busy <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (frame_done_c) begin
            if (more_c) begin
              byte_idx <= nxt_c[AW-1:0];
            end else begin
              st   <= ST_FIN;
              done <= 1'b1;
              busy <= 1'b0;
            end
          end
        end
        default: begin
          st   <= ST_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_tx.sv
// Self-checking bench for uart_msg_tx (DIV=4, DEPTH=4).
// Expected per-cycle line/busy/done/byte_idx values are queued when a block is
// requested and compared cycle by cycle as the DUT runs.
module tb_uart_msg_tx;

  localparam int unsigned DIV = 4;

  typedef struct {
    logic       ser;
    logic       busy;
    logic       done;
    logic       chk_idx;
    logic [1:0] idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst0, rst2, rstp;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] msg_len, len_p;
  logic       send0, send2, send_off;
  logic       busy0, done0, ser0;
  logic       busy2, done2, ser2;
  logic       busya, donea, sera;
  logic       busyb, doneb, serb;
  logic [1:0] idx0, idx2, idxa, idxb;

  logic       sel;
  logic       obs_ser, obs_busy, obs_done;
  logic [1:0] obs_idx;

  exp_t       exp_q[$];
  int         q100[$];
  int         q50[$];
  logic [7:0] bm [4];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs_ser  = sel ? ser2  : ser0;
  assign obs_busy = sel ? busy2 : busy0;
  assign obs_done = sel ? done2 : done0;
  assign obs_idx  = sel ? idx2  : idx0;

  uart_msg_tx #(.CLK_HZ(1000000), .BAUD(250000), .DEPTH(4), .STOP_BITS(1), .PERIOD_CYC(0)) u_d0 (
    .clk(clk), .rst(rst0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .send(send0), .busy(busy0), .done(done0), .serial(ser0), .byte_idx(idx0));

  uart_msg_tx #(.CLK_HZ(1000000), .BAUD(250000), .DEPTH(4), .STOP_BITS(2), .PERIOD_CYC(0)) u_d2 (
    .clk(clk), .rst(rst2), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .send(send2), .busy(busy2), .done(done2), .serial(ser2), .byte_idx(idx2));

  uart_msg_tx #(.CLK_HZ(1000000), .BAUD(250000), .DEPTH(4), .STOP_BITS(1), .PERIOD_CYC(100)) u_p100 (
    .clk(clk), .rst(rstp), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(len_p), .send(send_off), .busy(busya), .done(donea), .serial(sera), .byte_idx(idxa));

  uart_msg_tx #(.CLK_HZ(1000000), .BAUD(250000), .DEPTH(4), .STOP_BITS(1), .PERIOD_CYC(50)) u_p50 (
    .clk(clk), .rst(rstp), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(len_p), .send(send_off), .busy(busyb), .done(doneb), .serial(serb), .byte_idx(idxb));

  function automatic void push_exp(logic s, logic b, logic d, logic ci, logic [1:0] ix);
    exp_t e;
    e.ser = s; e.busy = b; e.done = d; e.chk_idx = ci; e.idx = ix;
    exp_q.push_back(e);
  endfunction

  // n frames from the bench's buffer model, then the done cycle.
  function automatic void push_frames(int n, int sb);
    logic [7:0] b;
    logic       v;
    for (int k = 0; k < n; k++) begin
      b = bm[k];
      for (int bp = 0; bp < 9 + sb; bp++) begin
        if (bp == 0)      v = 1'b0;
        else if (bp <= 8) v = b[bp-1];
        else              v = 1'b1;
        for (int c = 0; c < int'(DIV); c++) push_exp(v, 1'b1, 1'b0, 1'b1, 2'(k));
      end
    end
    push_exp(1'b1, 1'b0, 1'b1, (n > 0), 2'(n - 1));
  endfunction

  // Advance one cycle, comparing the scoreboard head against the selected DUT.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_ser !== e.ser || obs_busy !== e.busy || obs_done !== e.done ||
          (e.chk_idx && obs_idx !== e.idx)) begin
        errors++;
        $display("FAIL line cyc=%0d got ser=%b busy=%b done=%b idx=%0d want ser=%b busy=%b done=%b idx=%0d",
                 cyc, obs_ser, obs_busy, obs_done, obs_idx, e.ser, e.busy, e.done, e.idx);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d expected cycles left, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic write_byte(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d; bm[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst2 = 1'b1; rstp = 1'b1;
    step(); step();
    rst0 = 1'b0; rst2 = 1'b0; rstp = 1'b0;
    checks++;
    if ({ser0, busy0, done0, idx0} !== 5'b10000) begin
      errors++; $display("FAIL reset d0: got %b want 10000", {ser0, busy0, done0, idx0});
    end
    checks++;
    if ({ser2, busy2, done2, idx2} !== 5'b10000) begin
      errors++; $display("FAIL reset d2: got %b want 10000", {ser2, busy2, done2, idx2});
    end
    checks++;
    if ({sera, busya, donea, idxa, serb, busyb, doneb, idxb} !== 10'b1000010000) begin
      errors++;
      $display("FAIL reset periodic: got %b want 1000010000",
               {sera, busya, donea, idxa, serb, busyb, doneb, idxb});
    end
  endtask

  task automatic test_abcd();
    sel = 1'b0; msg_len = 3'd4;
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    push_frames(4, 1);
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    send0 = 1'b1; step(); send0 = 1'b0;
    drain(400, "abcd");
  endtask

  task automatic test_zero_len();
    sel = 1'b0; msg_len = 3'd0;
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    push_frames(0, 1);
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    send0 = 1'b1; step(); send0 = 1'b0;
    drain(20, "zero_len");
  endtask

  // Clamp to DEPTH, plus writes during byte 0: byte 0 is already loaded, byte 3 is not.
  task automatic test_clamp_and_write();
    sel = 1'b0; msg_len = 3'd7;
    bm[3] = 8'h5A;
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    push_frames(4, 1);
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    send0 = 1'b1; step(); send0 = 1'b0;
    step(); step(); step();
    write_byte(2'd3, 8'h5A);
    write_byte(2'd0, 8'h30);
    drain(400, "clamp");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; msg_len = 3'd2;
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    push_frames(2, 1);
    push_frames(2, 1);
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    send0 = 1'b1;
    for (int i = 0; i < 82; i++) step();
    send0 = 1'b0;
    drain(200, "back_to_back");
  endtask

  task automatic test_two_stop();
    sel = 1'b1; msg_len = 3'd2;
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    push_frames(2, 2);
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    send2 = 1'b1; step(); send2 = 1'b0;
    drain(200, "two_stop");
  endtask

  task automatic test_reset_mid(input int sb);
    int  fl;
    bit  bad;
    fl  = (9 + sb) * int'(DIV);
    sel = (sb == 2);
    msg_len = 3'd4;
    if (sb == 2) send2 = 1'b1; else send0 = 1'b1;
    step();
    send0 = 1'b0; send2 = 1'b0;
    for (int i = 0; i < fl + 9; i++) step();
    checks++;
    if (obs_busy !== 1'b1 || obs_idx !== 2'd1) begin
      errors++;
      $display("FAIL reset_mid sb=%0d pre: got busy=%b idx=%0d want busy=1 idx=1", sb, obs_busy, obs_idx);
    end
    if (sb == 2) rst2 = 1'b1; else rst0 = 1'b1;
    step();
    rst0 = 1'b0; rst2 = 1'b0;
    checks++;
    if (obs_ser !== 1'b1 || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid sb=%0d post: got ser=%b busy=%b want ser=1 busy=0", sb, obs_ser, obs_busy);
    end
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (obs_done !== 1'b0 || obs_busy !== 1'b0 || obs_ser !== 1'b1) bad = 1'b1;
      step();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_mid sb=%0d quiet: got activity after reset, want none", sb);
    end
    msg_len = 3'd1;
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    push_frames(1, sb);
    push_exp(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    if (sb == 2) send2 = 1'b1; else send0 = 1'b1;
    step();
    send0 = 1'b0; send2 = 1'b0;
    drain(100, "reset_restart");
  endtask

  // Expected block start cycles relative to timer reset; PERIOD 50 drops every other tick.
  task automatic test_periodic();
    int  r;
    bit  prev_a, prev_b;
    rstp = 1'b1;
    r = cyc;
    q100.push_back(r + 101); q100.push_back(r + 201); q100.push_back(r + 301);
    q50.push_back(r + 51);   q50.push_back(r + 151);
    q50.push_back(r + 251);  q50.push_back(r + 351);
    step();
    rstp = 1'b0;
    prev_a = 1'b0; prev_b = 1'b0;
    for (int i = 0; i < 360; i++) begin
      @(negedge clk);
      if (busya && !prev_a) begin
        checks++;
        if (q100.size() == 0 || cyc != q100[0]) begin
          errors++;
          $display("FAIL period100 start: got cyc %0d want %0d", cyc - r,
                   (q100.size() > 0) ? q100[0] - r : -1);
        end
        if (q100.size() > 0) void'(q100.pop_front());
      end
      if (busyb && !prev_b) begin
        checks++;
        if (q50.size() == 0 || cyc != q50[0]) begin
          errors++;
          $display("FAIL period50 start: got cyc %0d want %0d", cyc - r,
                   (q50.size() > 0) ? q50[0] - r : -1);
        end
        if (q50.size() > 0) void'(q50.pop_front());
      end
      prev_a = busya; prev_b = busyb;
      @(posedge clk);
      #1;
    end
    checks++;
    if (q100.size() != 0 || q50.size() != 0) begin
      errors++;
      $display("FAIL periodic missing starts: got %0d/%0d left want 0/0", q100.size(), q50.size());
    end
  endtask

  initial begin
    rst0 = 1'b1; rst2 = 1'b1; rstp = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    msg_len = '0; len_p = 3'd2;
    send0 = 1'b0; send2 = 1'b0; send_off = 1'b0;
    sel = 1'b0;
    for (int i = 0; i < 4; i++) bm[i] = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    write_byte(2'd0, 8'h41);
    write_byte(2'd1, 8'h42);
    write_byte(2'd2, 8'h43);
    write_byte(2'd3, 8'h44);
    test_abcd();
    test_zero_len();
    test_clamp_and_write();
    test_back_to_back();
    test_two_stop();
    test_reset_mid(1);
    test_reset_mid(2);
    test_periodic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
